// File: rtl/sram_bridge.sv
// Bridge from the CPU valid/ready memory port to an asynchronous SRAM, with
// configurable read/write wait states, a write hold cycle and bus turnaround.
module sram_bridge #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 8,
    parameter int WAIT_RD = 1,
    parameter int WAIT_WR = 1,
    parameter int TURN    = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic              iReqWe,
    input  logic [ADDR_W-1:0] iReqAddr,
    input  logic [DATA_W-1:0] iReqData,
    output logic              oRspValid,
    output logic [DATA_W-1:0] oRspData,
    output logic              oBusy,
    output logic [ADDR_W-1:0] oSramAddr,
    inout  wire  [DATA_W-1:0] ioSramData,
    output logic              oSramWe,
    output logic              oSramOe
);

    localparam int MAX_WAIT_RW = (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
    localparam int MAX_CNT     = (MAX_WAIT_RW > TURN) ? MAX_WAIT_RW : TURN;
    localparam int CNT_W       = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_RD   = CNT_W'(WAIT_RD);
    localparam logic [CNT_W-1:0] CNT_WR   = CNT_W'(WAIT_WR);
    // TURN state lasts TURN cycles, so the counter starts one below it.
    localparam logic [CNT_W-1:0] CNT_TURN = CNT_W'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_HOLD,
        ST_TURN
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_next_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              w_accept;
    logic              w_sample;
    logic              w_drive;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (iReqValid) begin
                    w_accept = 1'b1;
                    if (iReqWe) begin
                        w_next_state = ST_WR;
                        w_next_cnt   = CNT_WR;
                    end else begin
                        w_next_state = ST_RD;
                        w_next_cnt   = CNT_RD;
                    end
                end
            end
            ST_RD: begin
                if (r_cnt == '0) begin
                    w_sample     = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            ST_WR: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (TURN > 0) begin
                    w_next_state = ST_TURN;
                    w_next_cnt   = CNT_TURN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_rsp_valid <= w_sample;
            if (w_accept) begin
                r_addr  <= iReqAddr;
                r_wdata <= iReqData;
            end
            if (w_sample) begin
                r_rsp_data <= ioSramData;
            end
        end
    end

    // Strobes decode straight from the state register; reset forces them low at once.
    assign w_drive    = (r_state == ST_WR) || (r_state == ST_HOLD);
    assign ioSramData = w_drive ? r_wdata : {DATA_W{1'bz}};
    assign oSramWe    = (r_state == ST_WR);
    assign oSramOe    = (r_state == ST_RD);
    assign oSramAddr  = r_addr;
    assign oReqReady  = (r_state == ST_IDLE);
    assign oBusy      = (r_state != ST_IDLE);
    assign oRspValid  = r_rsp_valid;
    assign oRspData   = r_rsp_data;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: default-parameter instance plus a zero-wait
// instance, each attached to a simple asynchronous SRAM model.
module tb_sram_bridge;

    logic clk;
    logic rst;

    logic        a_valid, a_we, a_ready, a_rsp_valid, a_busy, a_we_o, a_oe;
    logic [19:0] a_addr, a_sram_addr;
    logic [7:0]  a_wdata, a_rsp_data;
    wire  [7:0]  a_bus;

    logic        b_valid, b_we, b_ready, b_rsp_valid, b_busy, b_we_o, b_oe;
    logic [19:0] b_addr, b_sram_addr;
    logic [7:0]  b_wdata, b_rsp_data;
    wire  [7:0]  b_bus;

    logic [7:0] mem [0:4095];
    logic [7:0] rsp_q [$];

    int n_checks;
    int n_errors;
    int n_overlap;

    sram_bridge #(.ADDR_W(20), .DATA_W(8), .WAIT_RD(1), .WAIT_WR(1), .TURN(1)) u_dut_a (
        .iClk(clk), .iRst(rst),
        .iReqValid(a_valid), .oReqReady(a_ready), .iReqWe(a_we),
        .iReqAddr(a_addr), .iReqData(a_wdata),
        .oRspValid(a_rsp_valid), .oRspData(a_rsp_data), .oBusy(a_busy),
        .oSramAddr(a_sram_addr), .ioSramData(a_bus), .oSramWe(a_we_o), .oSramOe(a_oe)
    );

    sram_bridge #(.ADDR_W(20), .DATA_W(8), .WAIT_RD(0), .WAIT_WR(0), .TURN(0)) u_dut_b (
        .iClk(clk), .iRst(rst),
        .iReqValid(b_valid), .oReqReady(b_ready), .iReqWe(b_we),
        .iReqAddr(b_addr), .iReqData(b_wdata),
        .oRspValid(b_rsp_valid), .oRspData(b_rsp_data), .oBusy(b_busy),
        .oSramAddr(b_sram_addr), .ioSramData(b_bus), .oSramWe(b_we_o), .oSramOe(b_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: drives data while OE is high, stores on the falling edge of WE.
    assign a_bus = a_oe ? mem[a_sram_addr[11:0]] : 8'hzz;
    assign b_bus = b_oe ? mem[b_sram_addr[11:0]] : 8'hzz;

    always @(negedge a_we_o) if (!rst) mem[a_sram_addr[11:0]] = a_bus;
    always @(negedge b_we_o) if (!rst) mem[b_sram_addr[11:0]] = b_bus;

    always @(negedge clk) begin
        if ((a_we_o && a_oe) || (b_we_o && b_oe)) n_overlap++;
        if (a_rsp_valid) rsp_q.push_back(a_rsp_data);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Counts cycles after the accept cycle until the response strobe shows up.
    task automatic wait_rsp_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            a_valid = 1'b0;
        end while (!a_rsp_valid && n < 20);
    endtask

    task automatic wait_rsp_b(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            b_valid = 1'b0;
        end while (!b_rsp_valid && n < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int k;
        int i;
        int guard;
        int last_acc;
        logic acc;

        n_checks  = 0;
        n_errors  = 0;
        n_overlap = 0;
        for (int j = 0; j < 4096; j++) mem[j] = 8'h00;
        mem[12'h345] = 8'hA5;
        for (int j = 0; j < 8; j++) mem[j] = 8'(8'h80 + j);

        a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;

        // Reset state
        rst = 1'b0;
        #2 rst = 1'b1;
        #10;
        check("rst_we", {31'd0, a_we_o}, 32'd0);
        check("rst_oe", {31'd0, a_oe}, 32'd0);
        check("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_ready", {31'd0, a_ready}, 32'd1);
        check("rst_addr", {12'd0, a_sram_addr}, 32'd0);
        check("rst_rsp_data", {24'd0, a_rsp_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1. Read 0x12345 -> 0xA5
        a_valid = 1; a_we = 0; a_addr = 20'h12345;
        check("t1_ready_accept", {31'd0, a_ready}, 32'd1);
        @(negedge clk); a_valid = 0;
        check("t1_c1_oe", {31'd0, a_oe}, 32'd1);
        check("t1_c1_rsp", {31'd0, a_rsp_valid}, 32'd0);
        check("t1_c1_addr", {12'd0, a_sram_addr}, 32'h12345);
        @(negedge clk);
        check("t1_c2_oe", {31'd0, a_oe}, 32'd1);
        check("t1_c2_rsp", {31'd0, a_rsp_valid}, 32'd0);
        @(negedge clk);
        check("t1_c3_oe", {31'd0, a_oe}, 32'd0);
        check("t1_c3_rsp", {31'd0, a_rsp_valid}, 32'd1);
        check("t1_c3_data", {24'd0, a_rsp_data}, 32'hA5);
        check("t1_c3_ready", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        check("t1_c4_rsp", {31'd0, a_rsp_valid}, 32'd0);
        check("t1_c4_data_held", {24'd0, a_rsp_data}, 32'hA5);

        // 2. Write 0x3C @0x00010
        a_valid = 1; a_we = 1; a_addr = 20'h00010; a_wdata = 8'h3C;
        check("t2_ready_accept", {31'd0, a_ready}, 32'd1);
        @(negedge clk); a_valid = 0;
        check("t2_c1_we", {31'd0, a_we_o}, 32'd1);
        check("t2_c1_oe", {31'd0, a_oe}, 32'd0);
        check("t2_c1_bus", {24'd0, a_bus}, 32'h3C);
        @(negedge clk);
        check("t2_c2_we", {31'd0, a_we_o}, 32'd1);
        check("t2_c2_bus", {24'd0, a_bus}, 32'h3C);
        @(negedge clk);
        check("t2_c3_we", {31'd0, a_we_o}, 32'd0);
        check("t2_c3_bus", {24'd0, a_bus}, 32'h3C);
        check("t2_c3_addr", {12'd0, a_sram_addr}, 32'h00010);
        check("t2_c3_ready", {31'd0, a_ready}, 32'd0);
        @(negedge clk);
        check("t2_c4_ready", {31'd0, a_ready}, 32'd0);
        check("t2_c4_busy", {31'd0, a_busy}, 32'd1);
        @(negedge clk);
        check("t2_c5_ready", {31'd0, a_ready}, 32'd1);
        check("t2_mem", {24'd0, mem[12'h010]}, 32'h3C);
        check("t2_no_rsp", {31'd0, a_rsp_valid}, 32'd0);

        // 3. Write 0x77 then read same address with valid held high
        rsp_q.delete();
        a_valid = 1; a_we = 1; a_addr = 20'h00020; a_wdata = 8'h77;
        check("t3_ready_accept", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        a_we = 0;
        k = 1;
        while (!a_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t3_read_accept_cycle", k, 32'd5);
        wait_rsp_a(n);
        check("t3_rsp_latency", n, 32'd3);
        check("t3_rsp_data", {24'd0, a_rsp_data}, 32'h77);
        repeat (4) @(negedge clk);
        check("t3_rsp_count", rsp_q.size(), 32'd1);

        // 4. Zero wait states on the second instance
        b_valid = 1; b_we = 0; b_addr = 20'h00345;
        check("t4_ready_accept", {31'd0, b_ready}, 32'd1);
        wait_rsp_b(n);
        check("t4_rsp_latency", n, 32'd2);
        check("t4_rsp_data", {24'd0, b_rsp_data}, 32'hA5);
        b_valid = 1; b_we = 1; b_addr = 20'h00030; b_wdata = 8'h5A;
        check("t4_wr_ready_accept", {31'd0, b_ready}, 32'd1);
        @(negedge clk); b_valid = 0;
        check("t4_c1_we", {31'd0, b_we_o}, 32'd1);
        check("t4_c1_bus", {24'd0, b_bus}, 32'h5A);
        @(negedge clk);
        check("t4_c2_we", {31'd0, b_we_o}, 32'd0);
        check("t4_c2_ready", {31'd0, b_ready}, 32'd0);
        @(negedge clk);
        check("t4_c3_ready", {31'd0, b_ready}, 32'd1);
        check("t4_mem", {24'd0, mem[12'h030]}, 32'h5A);

        // 5. Asynchronous reset in the middle of a write
        a_valid = 1; a_we = 1; a_addr = 20'h00100; a_wdata = 8'hEE;
        @(negedge clk); a_valid = 0;
        check("t5_we_before", {31'd0, a_we_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_we_async", {31'd0, a_we_o}, 32'd0);
        check("t5_busy_async", {31'd0, a_busy}, 32'd0);
        check("t5_addr_async", {12'd0, a_sram_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready_after", {31'd0, a_ready}, 32'd1);
        check("t5_busy_after", {31'd0, a_busy}, 32'd0);

        // 6. Eight back-to-back reads, addresses 0..7
        rsp_q.delete();
        i = 0; guard = 0; last_acc = -1;
        a_we = 0;
        while (i < 8 && guard < 100) begin
            a_valid = 1; a_addr = 20'(i);
            acc = a_ready;
            if (acc) last_acc = guard;
            @(negedge clk);
            guard++;
            if (acc) i++;
        end
        a_valid = 0;
        check("t6_accepts", i, 32'd8);
        check("t6_last_accept_cycle", last_acc, 32'd21);
        repeat (6) @(negedge clk);
        check("t6_rsp_count", rsp_q.size(), 32'd8);
        for (int j = 0; j < 8; j++) begin
            if (j < rsp_q.size()) check($sformatf("t6_rsp%0d", j), {24'd0, rsp_q[j]}, 32'(8'h80 + j));
        end

        check("no_we_oe_overlap", n_overlap, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
